// File: rtl/demux4_tdm.sv
// demux4_tdm: 1-to-4 time-division demultiplexer.
// Collects one serial bit per valid beat. A beat with sof=1 marks slot 0.
// Slots 0..3 go into a shadow register. All four outputs a..d are loaded
// together on the 4th beat, and frame_valid pulses for one cycle.
// A restart mid-frame, or more than TIMEOUT idle clocks inside a frame,
// aborts the frame and pulses frame_err. The outputs keep their old values.
// Optional build macro DEMUX4_PARITY_EN: each frame carries a 5th beat that
// holds even parity over slots 0..3. It is checked in a CHECK state before
// the outputs are loaded.
module demux4_tdm #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sof,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [1:0] slot,
  output logic       busy,
  output logic       frame_valid,
  output logic       frame_err
);

`ifdef DEMUX4_PARITY_EN
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, RECV} state_t;
`endif

  // An idle cycle seen while the counter holds TIMEOUT-1 is the TIMEOUT-th one.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [3:0]      shadow;
  logic [TO_W-1:0] to_cnt;

`ifdef DEMUX4_PARITY_EN
  // Even parity: the parity beat must equal the XOR of the four data slots.
  function automatic logic parity_ok(input logic [3:0] data, input logic pbit);
    return pbit == ^data;
  endfunction
`endif

  // Frame state machine. Every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shadow      <= '0;
      to_cnt      <= '0;
      slot        <= 2'd0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      a           <= 1'b0;
      b           <= 1'b0;
      c           <= 1'b0;
      d           <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (din_valid && sof) begin
            shadow[0] <= din;
            slot      <= 2'd1;
            busy      <= 1'b1;
            state     <= RECV;
          end
        end
        default: begin
          if (din_valid && sof) begin
            // Premature restart: drop the partial frame and take this beat as slot 0.
            frame_err <= 1'b1;
            shadow[0] <= din;
            slot      <= 2'd1;
            to_cnt    <= '0;
            state     <= RECV;
          end else if (din_valid) begin
            to_cnt <= '0;
`ifdef DEMUX4_PARITY_EN
            if (state == CHECK) begin
              if (parity_ok(shadow, din)) begin
                a           <= shadow[0];
                b           <= shadow[1];
                c           <= shadow[2];
                d           <= shadow[3];
                frame_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
              slot  <= 2'd0;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (slot == 2'd3) begin
              // Slot stays at 3 while the parity beat is awaited.
              shadow[3] <= din;
              state     <= CHECK;
            end else begin
              shadow[slot] <= din;
              slot         <= slot + 2'd1;
            end
`else
            if (slot == 2'd3) begin
              // Slot 3 bypasses the shadow so all four outputs load on this edge.
              a           <= shadow[0];
              b           <= shadow[1];
              c           <= shadow[2];
              d           <= din;
              frame_valid <= 1'b1;
              slot        <= 2'd0;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              shadow[slot] <= din;
              slot         <= slot + 2'd1;
            end
`endif
          end else if (to_cnt == TO_LAST) begin
            frame_err <= 1'b1;
            to_cnt    <= '0;
            slot      <= 2'd0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux4_tdm.sv
// Bench for demux4_tdm. Directed frames are followed by random beats.
// Every cycle is compared against a frame-level model built from a bit queue.
module tb_demux4_tdm;
  localparam int TIMEOUT = 4;
`ifdef DEMUX4_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst, din, din_valid, sof;
  logic       a, b, c, d, busy, frame_valid, frame_err;
  logic [1:0] slot;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference model state
  bit         m_q[$];
  bit         m_inf;
  int         m_idle;
  logic [3:0] m_out;
  logic       m_fv, m_fe;

  demux4_tdm #(.TIMEOUT(TIMEOUT), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .a(a), .b(b), .c(c), .d(d), .slot(slot), .busy(busy),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Frame-level behaviour: collect bits, deliver the frame after NB bits.
  task automatic model(input logic r, input logic v, input logic s, input logic dd);
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_q.delete(); m_inf = 0; m_idle = 0; m_out = 4'b0000;
    end else if (v) begin
      if (s) begin
        if (m_inf) m_fe = 1'b1;
        m_q.delete(); m_q.push_back(dd); m_inf = 1; m_idle = 0;
      end else if (m_inf) begin
        m_q.push_back(dd); m_idle = 0;
        if (m_q.size() == NB) begin
          if (NB == 5 && dd != (m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3])) m_fe = 1'b1;
          else begin
            m_out = {m_q[0], m_q[1], m_q[2], m_q[3]};
            m_fv  = 1'b1;
          end
          m_q.delete(); m_inf = 0;
        end
      end
    end else if (m_inf) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        m_fe = 1'b1; m_q.delete(); m_inf = 0; m_idle = 0;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic s, input logic dd);
    int exp_slot;
    rst = r; din_valid = v; sof = s; din = dd;
    @(posedge clk);
    model(r, v, s, dd);
    #1;
    exp_slot = m_inf ? ((m_q.size() > 3) ? 3 : m_q.size()) : 0;
    chk("outs", {4'b0, a, b, c, d}, {4'b0, m_out});
    chk("slot", {6'b0, slot}, 8'(exp_slot));
    chk("busy", {7'b0, busy}, {7'b0, m_inf});
    chk("frame_valid", {7'b0, frame_valid}, {7'b0, m_fv});
    chk("frame_err", {7'b0, frame_err}, {7'b0, m_fe});
    chk("excl", {7'b0, frame_valid & frame_err}, 8'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends slots 0..3 (bits[3] first = slot 0), plus a parity beat when enabled.
  task automatic send_frame(input logic [3:0] bits, input int gap, input logic good_par);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, (i == 0), bits[3-i]);
      if (i < 3) idle(gap);
    end
    if (NB == 5) cyc(1'b0, 1'b1, 1'b0, good_par ? ^bits : ~^bits);
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; sof = 1'b0;
    m_q.delete(); m_inf = 0; m_idle = 0; m_out = 4'b0; m_fv = 0; m_fe = 0;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);

    // Back-to-back beats, frame 1011
    send_frame(4'b1011, 0, 1'b1);
    chk("f1_out", {4'b0, a, b, c, d}, 8'b1011);
    chk("f1_fv", {7'b0, frame_valid}, 8'd1);
    idle(1);
    chk("f1_fv_off", {7'b0, frame_valid}, 8'd0);

    // Same frame with 3 idle cycles between beats, starting from reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(4'b1011, 3, 1'b1);
    chk("f2_out", {4'b0, a, b, c, d}, 8'b1011);

    // Premature restart: sof, 2 beats, sof again; then a normal frame 0110
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("restart_err", {7'b0, frame_err}, 8'd1);
    chk("restart_out", {4'b0, a, b, c, d}, 8'b1011);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    if (NB == 5) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("restart_new", {4'b0, a, b, c, d}, 8'b0110);

    // Back-to-back frames
    send_frame(4'b1100, 0, 1'b1);
    send_frame(4'b0011, 0, 1'b1);
    chk("b2b_out", {4'b0, a, b, c, d}, 8'b0011);

    // Non-sof beats in IDLE are dropped
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("idle_busy", {7'b0, busy}, 8'd0);

    // Timeout: 2 beats then TIMEOUT idle cycles
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(TIMEOUT);
    chk("to_err", {7'b0, frame_err}, 8'd1);
    chk("to_busy", {7'b0, busy}, 8'd0);
    chk("to_out", {4'b0, a, b, c, d}, 8'b0011);

    // Reset mid-frame
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid", {1'b0, a, b, c, d, busy, frame_err, frame_valid}, 8'd0);

`ifdef DEMUX4_PARITY_EN
    send_frame(4'b1011, 0, 1'b1);
    chk("par_ok", {4'b0, a, b, c, d}, 8'b1011);
    send_frame(4'b0101, 0, 1'b0);
    chk("par_bad_err", {7'b0, frame_err}, 8'd1);
    chk("par_bad_out", {4'b0, a, b, c, d}, 8'b1011);
`endif

    // Random beats
    for (int i = 0; i < 4000; i++) begin
      logic r, v, s, dd;
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 9) < 6);
      s  = ($urandom_range(0, 9) < 2);
      dd = 1'($urandom);
      cyc(r, v, s, dd);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/demux4_tdm.md
Name: demux4_tdm

Overview:
- 1-to-4 time-division demultiplexer. It receives a serial bit stream, one bit per valid beat, framed by a start-of-frame flag, and distributes slots 0..3 to four registered outputs.
- It is the receiving end for a 4-to-1 selector, which serializes four inputs a/b/c/d onto one wire by stepping its 2-bit select.
- On the board, outputs drive LEDs or downstream logic; the frame strobe marks each coherent update.

Parameters:
- TIMEOUT, 255, max idle clocks allowed between beats inside a frame before abort (1..65535).
- TO_W, 16, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  input  1  system clock (12 MHz on board).
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is a beat this cycle.
- sof  input  1  qualifies a beat as slot 0 of a frame; ignored when din_valid=0.
- a  output  1  slot 0 value, registered.
- b  output  1  slot 1 value, registered.
- c  output  1  slot 2 value, registered.
- d  output  1  slot 3 value, registered.
- slot  output  2  index the next beat will be written to (mirrors the selector's sel).
- busy  output  1  1 while a frame is in progress.
- frame_valid  output  1  1-cycle pulse when a, b, c, d update.
- frame_err  output  1  1-cycle pulse on aborted frame.

Behaviour:
- Reset (rst=1 sampled on a clk edge):
  - a=b=c=d=0, slot=0, busy=0, frame_valid=0, frame_err=0.
  - Shadow register=0, timeout counter=0, state=IDLE.
  - Reset mid-frame discards the partial frame with no error pulse.
- States: IDLE and RECV.
- IDLE:
  - din_valid=1 and sof=1: shadow[0]<=din, slot<=1, busy<=1, go to RECV.
  - din_valid=1 and sof=0: beat dropped, no error, stay in IDLE.
- RECV, on din_valid=1 and sof=0:
  - shadow[slot]<=din, slot<=slot+1, timeout counter cleared.
  - When the beat lands in slot 3 (4th beat): a..d<=shadow with slot 3 taken from din that same cycle, frame_valid=1 for one cycle, slot<=0, busy<=0, go to IDLE.
  - Latency: outputs change on the clock edge that samples the 4th beat and are visible the following cycle; all four update together.
- RECV, on din_valid=1 and sof=1 (premature restart):
  - frame_err pulses.
  - Partial frame discarded; outputs keep their previous values.
  - The beat is taken as slot 0 of a new frame: shadow[0]<=din, slot<=1, stay in RECV.
- RECV, on din_valid=0:
  - Timeout counter increments.
  - When it reaches TIMEOUT: frame_err pulses, slot<=0, busy<=0, go to IDLE, outputs unchanged.
- frame_valid and frame_err are never high in the same cycle.
- Back-to-back frames: a sof beat in the cycle right after the 4th beat is accepted normally.
- slot wraps 3 to 0 only via frame completion or abort.

Optional Feature:
- Macro: DEMUX4_PARITY_EN.
- Defined:
  - Each frame carries a 5th beat holding even parity over slots 0..3.
  - After slot 3 the block waits in a CHECK state, with busy still 1 and slot held at 3.
  - On the parity beat (din_valid=1, sof=0): if din equals XOR of slots 0..3, outputs update and frame_valid pulses; otherwise frame_err pulses and outputs are unchanged. Either way it returns to IDLE.
  - sof and timeout rules inside CHECK are the same as in RECV.
- Undefined: no CHECK state; 4-beat frames exactly as described above.

Test Plan:
- Reset, then beats (sof=1,din=1),(0,0),(0,1),(0,1) on consecutive cycles -> one cycle later a=1,b=0,c=1,d=1, frame_valid high for exactly 1 cycle, busy=0, slot=0.
- Same frame with 3 idle cycles between each beat, TIMEOUT=255 -> identical result, and a..d stay 0 until the 4th beat.
- Frame 1011 completes, then sof=1,din=0 followed by 2 beats, then sof=1 again -> frame_err pulses once, a..d remain 1011, and the new frame then completes normally.
- Beats with sof=0 while in IDLE -> no change on any output, busy=0.
- TIMEOUT=4: 2 beats then 4 idle cycles -> frame_err on the 4th idle cycle, busy=0, outputs unchanged; assert rst mid-frame -> all outputs 0 next cycle.
- With DEMUX4_PARITY_EN: frame 1,0,1,1 followed by parity 1 -> outputs update; same frame with parity 0 -> frame_err, outputs unchanged.
